psk_symbol_mapper: RTL
======================

Name: psk_symbol_mapper

Overview:
Parametrised successor to the Tx symbol path. It accepts an AXI-Stream byte stream and serialises each byte MSB-first into BPSK, QPSK or MIX symbols, where MIX uses BPSK for header bytes and QPSK for payload bytes. Each symbol is held for SPS clocks as signed I/Q DAC levels. All DAC-side outputs pass through a run-time programmable alignment delay. The block sits between the framing/data source and the DAC interface.

Parameters:
DATA_W, 8, stream byte width in bits; must be even and at least 2.
DAC_W, 12, signed DAC sample width.
SPS, 16, clk cycles per symbol; must be at least 2.
AMP, 1024, symbol magnitude; must be less than 2^(DAC_W-1).
DELAY_MAX, 15, maximum alignment delay in cycles; DELAY_CNT width is $clog2(DELAY_MAX+1).

Ports:
clk_16M384  in  1  sample clock, the only clock
rst_n_16M384  in  1  asynchronous active-low reset
MODE_CTRL  in  4  one-hot mode select: 0001 BPSK, 0010 QPSK, 0100 MIX
DELAY_CNT  in  $clog2(DELAY_MAX+1)  output alignment delay in cycles
data_tdata  in  DATA_W  input byte
data_tvalid  in  1  AXIS valid
data_tready  out  1  AXIS ready
data_tlast  in  1  last byte of frame
data_tuser  in  1  1 = header byte (BPSK in MIX mode)
DAC_I  out  DAC_W  signed in-phase sample
DAC_Q  out  DAC_W  signed quadrature sample
DAC_bits  out  2  current symbol bits {b1,b0}; BPSK drives {0,b}
DAC_vld  out  1  a symbol is being driven
Tx_1bit  out  1  MSB bit of the current symbol
frame_done  out  1  one-cycle pulse at the end of the last symbol of a tlast byte

Behaviour:
- Reset (asynchronous): every output and every delay-line stage goes to 0; the FSM goes to IDLE.
- FSM states:
  - IDLE: tready = 1 when MODE_CTRL is valid. A handshake loads the shift register, latches the mode (MIX resolves per byte from tuser), latches tlast, clears the symbol counter and moves to SEND.
  - SEND: the symbol counter counts 0..SPS-1. At SPS-1 the FSM either advances to the next symbol or finishes the byte.
  - End of byte (last symbol, counter at SPS-1): tready = 1 in this cycle.
    - Handshake in this cycle: the next byte loads with no gap.
    - No handshake: return to IDLE.
- bits/symbol is 1 (BPSK) or 2 (QPSK); symbols/byte is DATA_W or DATA_W/2.
- MODE_CTRL and tuser are sampled only at byte load; changes mid-byte are ignored.
- Invalid MODE_CTRL (not one of the three codes) in IDLE: tready = 0, outputs stay 0. The current byte always completes.
- Mapping, with +A = AMP and -A = -AMP, two's complement:
  - BPSK: 0 -> I = +A, 1 -> I = -A; Q = 0.
  - QPSK (Gray): I = b1 ? -A : +A; Q = b0 ? -A : +A.
- IDLE output: DAC_I = DAC_Q = 0, DAC_vld = 0, DAC_bits = 0.
- Latency: the first symbol appears 1 + DELAY_CNT cycles after the accepting edge.
- Delay line: DAC_I, DAC_Q, DAC_bits, DAC_vld, Tx_1bit and frame_done are all delayed equally.
- DELAY_CNT > DELAY_MAX is saturated to DELAY_MAX.
- A DELAY_CNT change takes effect immediately; glitches on the delayed outputs are permitted for up to DELAY_MAX cycles.
- frame_done asserts in the last cycle of the last symbol of a tlast byte, before the delay line.
- Underflow: the FSM returns to IDLE and zero output resumes. There is no error flag.

Optional Feature:
Macro PSK_TX_DIFF_ENC_EN.
- Defined: differential encoding.
  - A phase index p (mod 2 for BPSK, mod 4 for QPSK) is kept.
  - BPSK: p += b.
  - QPSK: p += {00:0, 01:1, 11:2, 10:3}.
  - Output constellation is p0 = (+A,+A), p1 = (-A,+A), p2 = (-A,-A), p3 = (+A,-A); BPSK uses ±A on I.
  - p resets to 0 on reset and at the first byte after IDLE or after a tlast byte.
  - In MIX mode the BPSK and QPSK symbols share one p, taken mod 2 and mod 4 respectively.
- Undefined: direct mapping as above; no phase-state logic is synthesised.

Decomposition:
- Package psk_tx_pkg holds:
  - MODE_BPSK, MODE_QPSK, MODE_MIX constants;
  - the FSM state typedef (IDLE, SEND);
  - QPSK Gray-to-phase-increment and phase-to-IQ sign functions.
- Sub-module psk_delay_line (parametrised WIDTH, DELAY_MAX) provides a variable-tap shift register used for all DAC-side outputs.

Test Plan:
1. BPSK, DELAY_CNT = 0, one byte 0xA5 with tlast = 1 -> 8 symbols of 16 cycles each. DAC_I = C00,400,C00,400,400,C00,400,C00 (hex); DAC_Q = 0. frame_done pulses at cycle 128 relative to the first symbol. DAC_vld then drops.
2. QPSK, byte 0x1B -> (I,Q) = (400,400), (400,C00), (C00,400), (C00,C00). Four symbols, 64 cycles.
3. MIX, bytes 0xF0 (tuser = 1) then 0x00 (tuser = 0), tvalid held high -> 8 BPSK symbols then 4 symbols of (400,400). tready is high only at the accept cycle and at cycle 127. There is no gap between the bytes.
4. Repeat scenario 1 with DELAY_CNT = 8 -> all outputs are identical but shifted by exactly 8 cycles. DELAY_CNT = 15 gives a 15-cycle shift.
5. Underflow: one byte is sent, then tvalid = 0 for 40 cycles -> after the last symbol, DAC_vld = 0 and I/Q = 0. Re-asserting tvalid accepts the byte next cycle and the first symbol follows 1 cycle later.
6. Assert rst_n low at cycle 40 of a BPSK byte -> all outputs are 0 immediately and tready = 0. After release the next byte starts at symbol 0 (with PSK_TX_DIFF_ENC_EN defined: p = 0).

Source files
------------

// File: rtl/psk_symbol_mapper_pkg.sv
// Shared constants, FSM state type and constellation helpers for the PSK symbol mapper.
package psk_tx_pkg;

  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  typedef enum logic {IDLE, SEND} state_t;

  // Gray-coded dibit to phase increment: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gray_to_inc(input logic [1:0] g);
    case (g)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Phase index to {i_neg, q_neg}: p0=(+,+) p1=(-,+) p2=(-,-) p3=(+,-)
  function automatic logic [1:0] phase_sign(input logic [1:0] p);
    return {p[1] ^ p[0], p[1]};
  endfunction

endpackage

// File: rtl/psk_symbol_mapper_if.sv
// AXI-Stream byte input of the PSK symbol mapper.
interface psk_symbol_mapper_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_tdata;
  logic              data_tvalid;
  logic              data_tready;
  logic              data_tlast;
  logic              data_tuser;

  modport master (output data_tdata, data_tvalid, data_tlast, data_tuser, input data_tready);
  modport slave  (input data_tdata, data_tvalid, data_tlast, data_tuser, output data_tready);
endinterface

// File: rtl/psk_delay_line.sv
// Variable-tap alignment delay; tap 0 is a pass-through, taps above DELAY_MAX saturate.
module psk_delay_line #(
  parameter  int WIDTH     = 1,
  parameter  int DELAY_MAX = 15,
  localparam int DW        = $clog2(DELAY_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    dly,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DELAY_MAX-1:0][WIDTH-1:0] dl_pipe;
  logic [DW-1:0]                   tap;

  assign tap = (dly > DW'(DELAY_MAX)) ? DW'(DELAY_MAX) : dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_pipe <= '0;
    end else begin
      dl_pipe[0] <= d;
      for (int i = 1; i < DELAY_MAX; i++) dl_pipe[i] <= dl_pipe[i-1];
    end
  end

  always_comb begin
    q = d;
    if (tap != '0) q = dl_pipe[tap - DW'(1)];
  end
endmodule

// File: rtl/psk_symbol_mapper.sv
// Serialises AXIS bytes MSB-first into BPSK/QPSK/MIX I/Q DAC levels held SPS clocks per symbol.
// Define PSK_TX_DIFF_ENC_EN for differential (phase-accumulating) encoding.
module psk_symbol_mapper
  import psk_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DAC_W     = 12,
  parameter int SPS       = 16,
  parameter int AMP       = 1024,
  parameter int DELAY_MAX = 15
) (
  input  logic                             clk_16M384,
  input  logic                             rst_n_16M384,
  input  logic [3:0]                       MODE_CTRL,
  input  logic [$clog2(DELAY_MAX+1)-1:0]   DELAY_CNT,
  psk_symbol_mapper_if.slave               data,
  output logic signed [DAC_W-1:0]          DAC_I,
  output logic signed [DAC_W-1:0]          DAC_Q,
  output logic [1:0]                       DAC_bits,
  output logic                             DAC_vld,
  output logic                             Tx_1bit,
  output logic                             frame_done
);
  localparam int CNT_W = $clog2(SPS);
  localparam int SYM_W = $clog2(DATA_W);
  localparam int DL_W  = 2*DAC_W + 5;
  localparam logic signed [DAC_W-1:0] POS = DAC_W'(AMP);
  localparam logic signed [DAC_W-1:0] NEG = -POS;

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic              qpsk_l, tlast_l;
  logic [CNT_W-1:0]  cnt;
  logic [SYM_W-1:0]  sym;
  logic [1:0]        sym_bits;
  logic              i_neg, q_neg;
  logic              mode_ok, load_qpsk, last_sym, sym_end, byte_end, hs;

  logic signed [DAC_W-1:0] i_r, q_r;
  logic [1:0]              bits_r;
  logic                    vld_r, tx_r, fd_r;
  logic [DL_W-1:0]         dl_q;

  assign mode_ok   = (MODE_CTRL == MODE_BPSK) | (MODE_CTRL == MODE_QPSK) | (MODE_CTRL == MODE_MIX);
  assign load_qpsk = (MODE_CTRL == MODE_QPSK) | ((MODE_CTRL == MODE_MIX) & ~data.data_tuser);
  assign last_sym  = qpsk_l ? (sym == SYM_W'(DATA_W/2 - 1)) : (sym == SYM_W'(DATA_W - 1));
  assign sym_end   = (cnt == CNT_W'(SPS - 1));
  assign byte_end  = (state == SEND) & sym_end & last_sym;
  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign data.data_tready = rst_n_16M384 & mode_ok & ((state == IDLE) | byte_end);
  assign hs = data.data_tvalid & data.data_tready;

`ifdef PSK_TX_DIFF_ENC_EN
  logic [1:0] p_base, p_cur;

  always_comb begin
    sym_bits = qpsk_l ? sh[DATA_W-1 -: 2] : {1'b0, sh[DATA_W-1]};
    p_cur    = qpsk_l ? (p_base + gray_to_inc(sym_bits)) : {1'b0, p_base[0] ^ sym_bits[0]};
    {i_neg, q_neg} = phase_sign(p_cur);
  end
`else
  always_comb begin
    sym_bits = qpsk_l ? sh[DATA_W-1 -: 2] : {1'b0, sh[DATA_W-1]};
    i_neg    = qpsk_l ? sym_bits[1] : sym_bits[0];
    q_neg    = sym_bits[0];
  end
`endif

  always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
    if (!rst_n_16M384) begin
      state   <= IDLE;
      sh      <= '0;
      qpsk_l  <= 1'b0;
      tlast_l <= 1'b0;
      cnt     <= '0;
      sym     <= '0;
      i_r     <= '0;
      q_r     <= '0;
      bits_r  <= '0;
      vld_r   <= 1'b0;
      tx_r    <= 1'b0;
      fd_r    <= 1'b0;
`ifdef PSK_TX_DIFF_ENC_EN
      p_base  <= '0;
`endif
    end else begin
      if (state == SEND) begin
        vld_r  <= 1'b1;
        bits_r <= sym_bits;
        tx_r   <= sh[DATA_W-1];
        i_r    <= i_neg ? NEG : POS;
        q_r    <= !qpsk_l ? '0 : (q_neg ? NEG : POS);
        fd_r   <= byte_end & tlast_l;
      end else begin
        vld_r  <= 1'b0;
        bits_r <= '0;
        tx_r   <= 1'b0;
        i_r    <= '0;
        q_r    <= '0;
        fd_r   <= 1'b0;
      end

      if (hs) begin
        state   <= SEND;
        sh      <= data.data_tdata;
        qpsk_l  <= load_qpsk;
        tlast_l <= data.data_tlast;
        cnt     <= '0;
        sym     <= '0;
      end else if (state == SEND) begin
        if (sym_end) begin
          cnt <= '0;
          if (last_sym) begin
            state <= IDLE;
          end else begin
            sym <= sym + SYM_W'(1);
            sh  <= qpsk_l ? (sh << 2) : (sh << 1);
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

`ifdef PSK_TX_DIFF_ENC_EN
      // Phase restarts for a byte loaded from IDLE or right after a frame end.
      if (hs && ((state == IDLE) || tlast_l)) p_base <= '0;
      else if ((state == SEND) && sym_end)    p_base <= p_cur;
`endif
    end
  end

  psk_delay_line #(.WIDTH(DL_W), .DELAY_MAX(DELAY_MAX)) u_dly (
    .clk   (clk_16M384),
    .rst_n (rst_n_16M384),
    .dly   (DELAY_CNT),
    .d     ({vld_r, bits_r, tx_r, fd_r, i_r, q_r}),
    .q     (dl_q)
  );

  assign {DAC_vld, DAC_bits, Tx_1bit, frame_done, DAC_I, DAC_Q} = dl_q;
endmodule
